// File: rtl/maptable_ckpt_ctrl.sv
// ---------------------------------------------------------------------------
// maptable_ckpt_ctrl
// Branch checkpoint controller for the speculative register map table.
// A dispatching branch takes a checkpoint slot, and the slot stores a copy of
// the map state. Live slots are kept in age order in a circular buffer,
// oldest at head and youngest at tail-1. When a branch mispredicts, its slot
// and all younger slots are reclaimed. The map table is then restored from
// the saved copy through a one-cycle registered pulse.
//
// Ports
//   i_clock            system clock, rising edge
//   i_reset            asynchronous active-low reset
//   i_flush            precise-state recovery; discards every checkpoint
//   i_alloc_req        branch dispatching this cycle wants a checkpoint
//   i_alloc_map        map state to capture on grant
//   o_alloc_gnt        checkpoint granted this cycle (combinational)
//   o_alloc_tag        slot id assigned on grant (tail index)
//   o_full             all slots between head and tail; branches must stall
//   i_resolve_valid    a branch resolves this cycle
//   i_resolve_tag      checkpoint id of the resolving branch
//   i_resolve_mispred  1 = mispredicted, 0 = correctly predicted
//   o_restore_en       registered pulse; map table loads o_restore_map
//   o_restore_map      snapshot being restored, valid with o_restore_en
//   o_live_mask        valid bit per slot
//   o_count            slots between head and tail (incl. freed-not-reclaimed)
//
// Allocation handshake: i_alloc_req acts as valid. o_alloc_gnt acts as ready
// qualified by valid. A checkpoint is consumed on a rising edge only when
// i_alloc_req and o_alloc_gnt are both high. The requester holds the
// request (and the map) until it sees a grant.
// ---------------------------------------------------------------------------
module maptable_ckpt_ctrl #(
    parameter int NCKPT = 4,
    parameter int PR_W  = 6
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_flush,
    input  logic                           i_alloc_req,
    input  logic [32*PR_W-1:0]             i_alloc_map,
    output logic                           o_alloc_gnt,
    output logic [$clog2(NCKPT)-1:0]       o_alloc_tag,
    output logic                           o_full,
    input  logic                           i_resolve_valid,
    input  logic [$clog2(NCKPT)-1:0]       i_resolve_tag,
    input  logic                           i_resolve_mispred,
    output logic                           o_restore_en,
    output logic [32*PR_W-1:0]             o_restore_map,
    output logic [NCKPT-1:0]               o_live_mask,
    output logic [$clog2(NCKPT):0]         o_count
);

    localparam int CW = $clog2(NCKPT);
    localparam int MW = 32 * PR_W;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [CW:0]       r_head;
    logic [CW:0]       r_tail;
    logic [NCKPT-1:0]  r_valid;
    logic [MW-1:0]     r_snap [NCKPT];
    logic              r_restore_en;
    logic [MW-1:0]     r_restore_map;

    logic [CW:0]       w_count;
    logic              w_full;
    logic [CW-1:0]     w_head_idx;
    logic [CW-1:0]     w_tail_idx;
    logic              w_tag_live;
    logic              w_mispred;
    logic              w_correct;
    logic              w_alloc_gnt;
    logic              w_reclaim;
    logic [CW-1:0]     w_mp_off;
    logic [CW:0]       w_mp_tail;
    logic [NCKPT-1:0]  w_kill;
    logic [NCKPT-1:0]  w_valid_nxt;
    logic [CW-1:0]     w_slot_off;

    assign w_count    = r_tail - r_head;
    assign w_full     = (w_count == (CW+1)'(NCKPT));
    assign w_head_idx = r_head[CW-1:0];
    assign w_tail_idx = r_tail[CW-1:0];

    // Resolves aimed at slots that are not live are dropped entirely.
    assign w_tag_live = r_valid[i_resolve_tag];
    assign w_mispred  = i_resolve_valid & i_resolve_mispred & w_tag_live;
    assign w_correct  = i_resolve_valid & ~i_resolve_mispred & w_tag_live;

    // Grant uses the registered full. A reclaim in the same cycle does not
    // open a slot until the next cycle.
    assign w_alloc_gnt = i_alloc_req & ~w_full & ~i_flush & ~w_mispred;

    // The reclaim looks only at the registered valid bits. A slot cleared by
    // a resolve this cycle therefore becomes reclaimable one cycle later.
    assign w_reclaim = (w_count != '0) & ~r_valid[w_head_idx]
                     & ~(w_mispred & (w_head_idx == i_resolve_tag));

    // The new tail has the same age offset from head as the mispredicted
    // slot. This keeps head <= tail <= old tail without handling the wrap
    // bit separately.
    assign w_mp_off  = i_resolve_tag - w_head_idx;
    assign w_mp_tail = r_head + {1'b0, w_mp_off};

    // A slot is killed when its age offset is at least the offset of the
    // mispredicted slot. Slots beyond the old tail are already invalid.
    always_comb begin
        w_kill     = '0;
        w_slot_off = '0;
        for (int i = 0; i < NCKPT; i++) begin
            w_slot_off = CW'(i) - w_head_idx;
            w_kill[i]  = (w_slot_off >= w_mp_off);
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_mispred) begin
            w_valid_nxt = r_valid & ~w_kill;
        end else begin
            if (w_correct)   w_valid_nxt[i_resolve_tag] = 1'b0;
            if (w_alloc_gnt) w_valid_nxt[w_tail_idx]    = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_valid       <= '0;
            r_restore_en  <= 1'b0;
            r_restore_map <= '0;
        end else if (i_flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_valid      <= '0;
            r_restore_en <= 1'b0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_restore_en <= w_mispred;
            if (w_mispred)   r_restore_map <= r_snap[i_resolve_tag];
            if (w_reclaim)   r_head <= r_head + 1'b1;
            if (w_mispred)   r_tail <= w_mp_tail;
            else if (w_alloc_gnt) r_tail <= r_tail + 1'b1;
        end
    end

    // Snapshot storage is not reset. A slot's contents matter only while its
    // valid bit is set.
    always_ff @(posedge i_clock) begin
        if (w_alloc_gnt) r_snap[w_tail_idx] <= i_alloc_map;
    end

    assign o_alloc_gnt   = w_alloc_gnt;
    assign o_alloc_tag   = w_tail_idx;
    assign o_full        = w_full;
    assign o_restore_en  = r_restore_en;
    assign o_restore_map = r_restore_map;
    assign o_live_mask   = r_valid;
    assign o_count       = w_count;

endmodule
